// File: rtl/mult_pkg.sv
// Shared constants and helpers for the pipelined multiplier.
// The per-stage payload struct lives in pipelined_mult_unit because its field
// widths depend on that module's N and TAG_W parameters.
package mult_pkg;

    localparam int MULT_PIPE_MIN = 2;
    localparam int MULT_PIPE_MAX = 5;
    localparam int MULT_MAX_W    = 64;   // widest operand abs_n handles

    // Rows remaining after lvl layers of 3:2 compression, starting from n rows.
    function automatic int csa_rows(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) r = r - r / 3;
        return r;
    endfunction

    // Number of 3:2 layers needed to reduce n rows to two.
    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = r - r / 3;
            l++;
        end
        return l;
    endfunction

    // n-bit magnitude of a zero-extended value. When signed_flag is set, the
    // value is read as n-bit two's complement. -2^(n-1) maps to 2^(n-1),
    // which still fits n unsigned bits.
    function automatic logic [MULT_MAX_W-1:0] abs_n(input logic [MULT_MAX_W-1:0] value,
                                                    input int n,
                                                    input logic signed_flag);
        logic [MULT_MAX_W-1:0] mask;
        mask = {MULT_MAX_W{1'b1}} >> (MULT_MAX_W - n);
        if (signed_flag && value[6'(n - 1)]) return (~value + MULT_MAX_W'(1)) & mask;
        return value & mask;
    endfunction

endpackage

// File: rtl/pipelined_mult_unit_wallace.sv
// Combinational N x N unsigned Wallace-tree multiplier.
// Partial-product rows are reduced by layers of 3:2 carry-save adders until
// two rows remain. One final carry-propagate add produces the product.
// All arithmetic is modulo 2^(2N). The exact product fits 2N bits, so carry
// bits shifted off the top are never significant.
module pipelined_mult_unit_wallace
    import mult_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod
);

    localparam int LEVELS = csa_levels(N);

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int R = csa_rows(N, l);
        logic [2*N-1:0] row [R];

        if (l == 0) begin : g_pp
            // Partial products: row i is a shifted by i when b[i] is set.
            for (genvar i = 0; i < N; i++) begin : g_row
                assign row[i] = b[i] ? ({{N{1'b0}}, a} << i) : '0;
            end
        end else begin : g_csa
            localparam int RP = csa_rows(N, l - 1);
            localparam int G  = RP / 3;
            // Each group of three rows compresses to one sum row and one carry row.
            for (genvar g = 0; g < G; g++) begin : g_fa
                logic [2*N-1:0] x, y, z;
                assign x = g_lvl[l-1].row[3*g];
                assign y = g_lvl[l-1].row[3*g+1];
                assign z = g_lvl[l-1].row[3*g+2];
                assign row[2*g]   = x ^ y ^ z;
                assign row[2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
            // Rows left over after grouping pass through to the next layer.
            for (genvar i = 3*G; i < RP; i++) begin : g_pass
                assign row[i-G] = g_lvl[l-1].row[i];
            end
        end
    end

    assign prod = g_lvl[LEVELS].row[0] + g_lvl[LEVELS].row[1];

endmodule

// File: rtl/pipelined_mult_unit.sv
// Handshaked signed/unsigned multiplier with PIPE valid/ready stages.
// Stage 1 holds the operand magnitudes. Stage 2 holds the unsigned Wallace
// product. Stage 3 applies the sign; later stages only add delay. The neg bit
// means "sign still pending": stage 3 clears it after negating. For PIPE=2 the
// output applies the sign combinationally instead.
// Valid stages advance independently, so bubbles collapse. The unit holds
// PIPE transactions in flight.
// Legal PIPE range is MULT_PIPE_MIN..MULT_PIPE_MAX. N must be at most
// MULT_MAX_W.
module pipelined_mult_unit
    import mult_pkg::*;
#(
    parameter int N     = 32,
    parameter int PIPE  = 3,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // data holds {|a|, |b|} in stage 1 and the product in later stages.
    typedef struct packed {
        logic [2*N-1:0]   data;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // Index of the negate stage. It is clamped so the dead branch stays
    // in range when PIPE=2.
    localparam int NEG_K = (PIPE >= 3) ? 3 : PIPE;

    stage_t          stg    [1:PIPE];
    stage_t          stg_in [1:PIPE];
    logic [PIPE:1]   vld_pipe;
    logic [PIPE:1]   adv;
    logic [PIPE:1]   load;
    logic [2*N-1:0]  mul_prod;

    pipelined_mult_unit_wallace #(.N(N)) u_wallace (
        .a    (stg[1].data[2*N-1:N]),
        .b    (stg[1].data[N-1:0]),
        .prod (mul_prod)
    );

    // Advance chain from the output back to the input, then ready and per-stage loads.
    always_comb begin
        adv       = '0;
        adv[PIPE] = vld_pipe[PIPE] & out_ready;
        for (int k = PIPE - 1; k >= 1; k--)
            adv[k] = vld_pipe[k] & (~vld_pipe[k+1] | adv[k+1]);
        in_ready = ~clear & (~vld_pipe[1] | adv[1]);
        load     = '0;
        load[1]  = in_valid & in_ready;
        for (int k = 2; k <= PIPE; k++)
            load[k] = adv[k-1];
    end

    // Next-payload values for each stage.
    always_comb begin
        for (int k = 1; k <= PIPE; k++) stg_in[k] = '0;
        stg_in[1].data = {N'(abs_n(MULT_MAX_W'(in_a), N, in_signed)),
                          N'(abs_n(MULT_MAX_W'(in_b), N, in_signed))};
        stg_in[1].neg  = in_signed & (in_a[N-1] ^ in_b[N-1]);
        stg_in[1].tag  = in_tag;
        stg_in[2].data = mul_prod;
        stg_in[2].neg  = stg[1].neg;
        stg_in[2].tag  = stg[1].tag;
        for (int k = 3; k <= PIPE; k++)
            stg_in[k] = stg[k-1];
        if (PIPE >= 3) begin
            stg_in[NEG_K].data = stg[NEG_K-1].neg ? -stg[NEG_K-1].data : stg[NEG_K-1].data;
            stg_in[NEG_K].neg  = 1'b0;
        end
    end

    // Stage valid bits. clear overrides any load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_pipe <= '0;
        else if (clear)
            vld_pipe <= '0;
        else
            for (int k = 1; k <= PIPE; k++)
                vld_pipe[k] <= load[k] | (vld_pipe[k] & ~adv[k]);
    end

    // Stage payload registers. A stage loads only when its upstream hands over.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= PIPE; k++) stg[k] <= '0;
        end else begin
            for (int k = 1; k <= PIPE; k++)
                if (load[k]) stg[k] <= stg_in[k];
        end
    end

    assign out_valid = vld_pipe[PIPE];
    assign out_prod  = stg[PIPE].neg ? -stg[PIPE].data : stg[PIPE].data;
    assign out_tag   = stg[PIPE].tag;
    assign busy      = |vld_pipe;

endmodule
